hangman_round_ctrl: RTL and testbench



---
 rtl/hangman_round_ctrl.sv | 153 +++++++++++++++
 tb/tb_hangman_round_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hangman_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hangman_round_ctrl
//  Purpose  : Hangman round sequencer. It filters key events, issues guess
//             strobes, tracks lives and decides win/lose.
//             Optional macro HANGMAN_DUP_PENALTY_EN: repeated guesses cost
//             a life.
//  Revision : 1.0  initial release
// ============================================================================
module hangman_round_ctrl #(
    parameter int MAX_LIVES = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        key_valid,
    input  logic [4:0]  key_letter,
    input  logic [25:0] word_mask,
    output logic        guess_load,
    output logic [4:0]  guess_letter,
    output logic [25:0] guessed,
    output logic [3:0]  lives,
    output logic        wrong,
    output logic        dup,
    output logic        win,
    output logic        lost,
    output logic [2:0]  state
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_PLAY  = 3'd1;
    localparam logic [2:0] c_CHECK = 3'd2;
    localparam logic [2:0] c_WON   = 3'd3;
    localparam logic [2:0] c_LOST  = 3'd4;

    localparam logic [3:0] c_MAX_LIVES   = 4'(MAX_LIVES);
    localparam logic [4:0] c_KEY_START   = 5'd26;
    localparam logic [4:0] c_NUM_LETTERS = 5'd26;

    logic [2:0]  r_state;
    logic [25:0] r_guessed;
    logic [3:0]  r_lives;
    logic [4:0]  r_guess_letter;
    logic        r_guess_load;
    logic        r_wrong;
    logic        r_dup;
    logic        r_win;
    logic        r_lost;

    logic [2:0]  w_state_nxt;
    logic [25:0] w_guessed_nxt;
    logic [3:0]  w_lives_nxt;
    logic [4:0]  w_letter_nxt;
    logic        w_load_nxt;
    logic        w_wrong_nxt;
    logic        w_dup_nxt;
    logic        w_start;
    logic        w_is_letter;
    logic [3:0]  w_lives_dec;

    assign w_start     = key_valid && (key_letter == c_KEY_START) && (|word_mask);
    assign w_is_letter = key_valid && (key_letter < c_NUM_LETTERS);
    // Lives saturate at zero rather than wrapping.
    assign w_lives_dec = (r_lives == 4'd0) ? 4'd0 : (r_lives - 4'd1);

    always_comb begin
        w_state_nxt   = r_state;
        w_guessed_nxt = r_guessed;
        w_lives_nxt   = r_lives;
        w_letter_nxt  = r_guess_letter;
        w_load_nxt    = 1'b0;
        w_wrong_nxt   = 1'b0;
        w_dup_nxt     = 1'b0;

        case (r_state)
            c_IDLE, c_WON, c_LOST: begin
                if (w_start) begin
                    w_state_nxt   = c_PLAY;
                    w_guessed_nxt = 26'd0;
                    w_lives_nxt   = c_MAX_LIVES;
                end
            end
            c_PLAY: begin
                if (w_is_letter) begin
                    w_state_nxt = c_CHECK;
                    if (r_guessed[key_letter]) begin
                        w_dup_nxt = 1'b1;
`ifdef HANGMAN_DUP_PENALTY_EN
                        w_wrong_nxt = 1'b1;
                        w_lives_nxt = w_lives_dec;
`endif
                    end else begin
                        w_load_nxt                = 1'b1;
                        w_letter_nxt              = key_letter;
                        w_guessed_nxt[key_letter] = 1'b1;
                        if (!word_mask[key_letter]) begin
                            w_wrong_nxt = 1'b1;
                            w_lives_nxt = w_lives_dec;
                        end
                    end
                end
            end
            c_CHECK: begin
                // Keys arriving here are dropped; losing takes priority over winning.
                if (r_lives == 4'd0) begin
                    w_state_nxt = c_LOST;
                end else if ((r_guessed & word_mask) == word_mask) begin
                    w_state_nxt = c_WON;
                end else begin
                    w_state_nxt = c_PLAY;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state        <= c_IDLE;
            r_guessed      <= 26'd0;
            r_lives        <= c_MAX_LIVES;
            r_guess_letter <= 5'd0;
            r_guess_load   <= 1'b0;
            r_wrong        <= 1'b0;
            r_dup          <= 1'b0;
            r_win          <= 1'b0;
            r_lost         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_guessed      <= w_guessed_nxt;
            r_lives        <= w_lives_nxt;
            r_guess_letter <= w_letter_nxt;
            r_guess_load   <= w_load_nxt;
            r_wrong        <= w_wrong_nxt;
            r_dup          <= w_dup_nxt;
            r_win          <= (w_state_nxt == c_WON);
            r_lost         <= (w_state_nxt == c_LOST);
        end
    end

    assign state        = r_state;
    assign guessed      = r_guessed;
    assign lives        = r_lives;
    assign guess_letter = r_guess_letter;
    assign guess_load   = r_guess_load;
    assign wrong        = r_wrong;
    assign dup          = r_dup;
    assign win          = r_win;
    assign lost         = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_hangman_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hangman_round_ctrl
//  Purpose  : Self-checking bench for hangman_round_ctrl using a cycle
//             reference model feeding an expected-result queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hangman_round_ctrl;

    localparam int        MAXL = 4;
    localparam logic [4:0] KEY_START = 5'd26;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        key_valid = 1'b0;
    logic [4:0]  key_letter = 5'd0;
    logic [25:0] word_mask = 26'd0;

    wire         guess_load;
    wire  [4:0]  guess_letter;
    wire  [25:0] guessed;
    wire  [3:0]  lives;
    wire         wrong;
    wire         dup;
    wire         win;
    wire         lost;
    wire  [2:0]  state;

    hangman_round_ctrl #(.MAX_LIVES(MAXL)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .key_valid   (key_valid),
        .key_letter  (key_letter),
        .word_mask   (word_mask),
        .guess_load  (guess_load),
        .guess_letter(guess_letter),
        .guessed     (guessed),
        .lives       (lives),
        .wrong       (wrong),
        .dup         (dup),
        .win         (win),
        .lost        (lost),
        .state       (state)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [42:0] sb_q[$];

    logic [2:0]  m_state   = 3'd0;
    logic [3:0]  m_lives   = 4'(MAXL);
    logic [25:0] m_guessed = 26'd0;
    logic [4:0]  m_letter  = 5'd0;
    logic        m_load    = 1'b0;
    logic        m_wrong   = 1'b0;
    logic        m_dup     = 1'b0;

    function automatic logic [42:0] obs_vec();
        return {state, lives, guessed, guess_letter, guess_load, wrong, dup, win, lost};
    endfunction

    function automatic logic [42:0] exp_vec();
        return {m_state, m_lives, m_guessed, m_letter, m_load, m_wrong, m_dup,
                (m_state == 3'd3), (m_state == 3'd4)};
    endfunction

    task automatic model_reset();
        m_state   = 3'd0;
        m_lives   = 4'(MAXL);
        m_guessed = 26'd0;
        m_letter  = 5'd0;
        m_load    = 1'b0;
        m_wrong   = 1'b0;
        m_dup     = 1'b0;
    endtask

    // Expected register contents after one clock with the current inputs.
    task automatic model_step();
        m_load  = 1'b0;
        m_wrong = 1'b0;
        m_dup   = 1'b0;
        case (m_state)
            3'd1: begin
                if (key_valid && key_letter < 5'd26) begin
                    if (m_guessed[key_letter]) begin
                        m_dup = 1'b1;
`ifdef HANGMAN_DUP_PENALTY_EN
                        m_wrong = 1'b1;
                        if (m_lives != 4'd0) m_lives = m_lives - 4'd1;
`endif
                    end else begin
                        m_load = 1'b1;
                        m_letter = key_letter;
                        m_guessed[key_letter] = 1'b1;
                        if (!word_mask[key_letter]) begin
                            m_wrong = 1'b1;
                            if (m_lives != 4'd0) m_lives = m_lives - 4'd1;
                        end
                    end
                    m_state = 3'd2;
                end
            end
            3'd2: begin
                if (m_lives == 4'd0)                          m_state = 3'd4;
                else if ((m_guessed & word_mask) == word_mask) m_state = 3'd3;
                else                                          m_state = 3'd1;
            end
            default: begin
                if (key_valid && key_letter == KEY_START && word_mask != 26'd0) begin
                    m_state   = 3'd1;
                    m_lives   = 4'(MAXL);
                    m_guessed = 26'd0;
                end
            end
        endcase
    endtask

    task automatic check_out(input string tag);
        logic [42:0] exp_v;
        logic [42:0] obs_v;
        exp_v = sb_q.pop_front();
        obs_v = obs_vec();
        checks++;
        assert (obs_v === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs_v, exp_v);
        end
    endtask

    task automatic expect_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Drive one cycle of stimulus, queue the model result, compare after the edge.
    task automatic step(input logic kv, input logic [4:0] kl, input string tag);
        key_valid  = kv;
        key_letter = kl;
        model_step();
        sb_q.push_back(exp_vec());
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        check_out(tag);
    endtask

    initial begin
        // Reset state while reset is held
        #12;
        model_reset();
        sb_q.push_back(exp_vec());
        check_out("reset_state");
        expect_val("reset_lives", 32'(lives), 32'd4);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // IDLE filtering: start with an empty word, letters in IDLE
        word_mask = 26'd0;
        step(1'b1, KEY_START, "start_empty_mask");
        step(1'b1, 5'd0, "idle_letter_a");
        expect_val("idle_state", 32'(state), 32'd0);

        // Start and win with word A|B
        word_mask = 26'h3;
        step(1'b1, KEY_START, "start_ab");
        expect_val("start_lives", 32'(lives), 32'd4);
        step(1'b1, 5'd0, "guess_a");
        expect_val("guess_a_load", 32'(guess_load), 32'd1);
        step(1'b0, 5'd0, "check_a");
        step(1'b1, 5'd1, "guess_b");
        step(1'b0, 5'd0, "check_b");
        expect_val("win_level", 32'({win, state}), 32'({1'b1, 3'd3}));
        step(1'b1, 5'd2, "won_hold");

        // Lose with word A, wrong guesses Z Y X W
        word_mask = 26'h1;
        step(1'b1, KEY_START, "restart_from_won");
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 5'(25 - i), "wrong_guess");
            expect_val("wrong_pulse", 32'(wrong), 32'd1);
            step(1'b0, 5'd0, "wrong_check");
        end
        expect_val("lost_level", 32'({lost, state, lives}), 32'({1'b1, 3'd4, 4'd0}));
        for (int i = 0; i < 26; i++) begin
            step(1'b1, 5'(i), "lost_ignore");
        end

        // Duplicate guess with word A|B
        word_mask = 26'h3;
        step(1'b1, KEY_START, "restart_from_lost");
        step(1'b1, 5'd25, "dup_first");
        step(1'b0, 5'd0, "dup_first_check");
        step(1'b1, 5'd25, "dup_second");
`ifdef HANGMAN_DUP_PENALTY_EN
        expect_val("dup_outputs", 32'({dup, guess_load, wrong, lives}), 32'({1'b1, 1'b0, 1'b1, 4'd2}));
`else
        expect_val("dup_outputs", 32'({dup, guess_load, wrong, lives}), 32'({1'b1, 1'b0, 1'b0, 4'd3}));
`endif
        step(1'b0, 5'd0, "dup_check");

        // Ignored codes in PLAY
        for (int i = 27; i < 32; i++) begin
            step(1'b1, 5'(i), "play_ignore_code");
        end
        step(1'b1, KEY_START, "play_ignore_start");
        expect_val("play_still", 32'(state), 32'd1);

        // Key in the CHECK cycle is dropped
        step(1'b1, 5'd0, "drop_first_a");
        step(1'b1, 5'd1, "drop_b_in_check");
        expect_val("drop_guessed", 32'(guessed), 32'h0200_0001);
        step(1'b0, 5'd0, "drop_after");

        // Asynchronous reset in CHECK after a wrong guess
        step(1'b1, 5'd24, "pre_reset_wrong");
        resetn = 1'b0;
        #1;
        model_reset();
        sb_q.push_back(exp_vec());
        check_out("async_reset");
        expect_val("async_reset_state", 32'(state), 32'd0);
        #2;
        resetn = 1'b1;

        // Restart after reset and win with word A
        word_mask = 26'h1;
        step(1'b1, KEY_START, "post_reset_start");
        step(1'b1, 5'd0, "post_reset_a");
        step(1'b0, 5'd0, "post_reset_check");
        expect_val("post_reset_win", 32'(win), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
